// File: rtl/line_err_pkg.sv
// Shared types, width helpers and default constants for the IR line error engine.
// Optional IIR smoothing of the error output is selected with the LINE_ERR_FILT_EN macro.
package line_err_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2
  } line_err_state_t;

  localparam int DEF_NCH_PER_SIDE = 4;
  localparam int DEF_ADC_W        = 12;
  localparam int DEF_ERR_W        = 16;
  localparam int DEF_LINE_THRESH  = 512;
  localparam int DEF_FILT_SHIFT   = 2;

  // Signed accumulator width: weighted sum of (R-L) over all pairs plus sign and margin.
  function automatic int acc_width(input int nch, input int adc_w);
    return adc_w + nch + 2;
  endfunction

  // Unsigned width holding the sum of all 2*nch readings.
  function automatic int sum_width(input int nch, input int adc_w);
    return adc_w + $clog2(2 * nch) + 1;
  endfunction

  // Clamp a signed value to the signed range of out_w bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                    input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/line_err_sat.sv
// Parametrised signed saturator: IN_W-bit signed input clamped to OUT_W-bit signed output.
// Shared by the main error path and the optional smoothing path (LINE_ERR_FILT_EN).
module line_err_sat
  import line_err_pkg::*;
#(
  parameter int IN_W  = 18,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  logic signed [63:0] din_ext;

  // Sign-extend to the helper width and clamp.
  always_comb begin
    din_ext = {{(64 - IN_W){din[IN_W-1]}}, din};
    dout    = OUT_W'(sat_signed(din_ext, OUT_W));
  end

endmodule

// File: rtl/line_err_engine.sv
// Binary-weighted differential IR steering error, one channel pair per clock,
// with a line-present decision on the summed reflectance.
// Build option: define LINE_ERR_FILT_EN to smooth the error with a first-order IIR
// (shift FILT_SHIFT), updated only on frames where the line is present.
module line_err_engine
  import line_err_pkg::*;
#(
  parameter int NCH_PER_SIDE = DEF_NCH_PER_SIDE,
  parameter int ADC_W        = DEF_ADC_W,
  parameter int ERR_W        = DEF_ERR_W,
  parameter int LINE_THRESH  = DEF_LINE_THRESH,
  parameter int FILT_SHIFT   = DEF_FILT_SHIFT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          IR_vld,
  input  logic [NCH_PER_SIDE*ADC_W-1:0] ir_r,
  input  logic [NCH_PER_SIDE*ADC_W-1:0] ir_l,
  output logic [ERR_W-1:0]              error,
  output logic                          err_vld,
  output logic                          line_present,
  output logic                          busy,
  output logic                          ovr
);

  localparam int ACC_W = acc_width(NCH_PER_SIDE, ADC_W);
  localparam int SUM_W = sum_width(NCH_PER_SIDE, ADC_W);
  localparam int K_W   = (NCH_PER_SIDE > 1) ? $clog2(NCH_PER_SIDE) : 1;
  localparam int IN_W  = NCH_PER_SIDE * ADC_W;
  localparam logic [K_W-1:0] K_LAST   = K_W'(NCH_PER_SIDE - 1);
  localparam logic [31:0]    THRESH_U = LINE_THRESH;
  // An out-of-range configuration leaves the engine inert instead of producing garbage.
  localparam bit CFG_OK = (NCH_PER_SIDE >= 1) && (NCH_PER_SIDE <= 6) &&
                          (FILT_SHIFT >= 0) && (FILT_SHIFT <= ERR_W) &&
                          (SUM_W <= 32);

  line_err_state_t state, state_nxt;

  logic [K_W-1:0]          k, k_nxt;
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic [SUM_W-1:0]        sum, sum_nxt;
  logic signed [ERR_W-1:0] err_q, err_nxt;
  logic                    line_nxt;
  logic                    err_vld_nxt;
  logic                    busy_nxt;
  logic                    ovr_nxt;
  logic                    snap_ld;

  logic [IN_W-1:0]         snap_r;
  logic [IN_W-1:0]         snap_l;

  logic [ADC_W-1:0]        r_k;
  logic [ADC_W-1:0]        l_k;
  logic signed [ADC_W:0]   diff;
  logic signed [ACC_W-1:0] diff_ext;
  logic signed [ACC_W-1:0] term;
  logic [31:0]             sum_ext;
  logic                    line_now;
  logic signed [ERR_W-1:0] sat_err;

  assign error = err_q;

  // Current channel pair and its weighted contribution.
  always_comb begin
    r_k      = snap_r[k*ADC_W +: ADC_W];
    l_k      = snap_l[k*ADC_W +: ADC_W];
    diff     = $signed({1'b0, r_k}) - $signed({1'b0, l_k});
    diff_ext = {{(ACC_W - ADC_W - 1){diff[ADC_W]}}, diff};
    term     = diff_ext <<< k;
    sum_ext  = {{(32 - SUM_W){1'b0}}, sum};
    line_now = (sum_ext >= THRESH_U);
  end

  line_err_sat #(
    .IN_W  (ACC_W),
    .OUT_W (ERR_W)
  ) u_sat (
    .din  (acc),
    .dout (sat_err)
  );

`ifdef LINE_ERR_FILT_EN
  logic                    primed, primed_nxt;
  logic signed [ERR_W:0]   f_diff;
  logic signed [ERR_W:0]   f_sum;
  logic signed [ERR_W-1:0] f_sat;

  // IIR step: err + ((sat - err) >>> FILT_SHIFT) with one guard bit.
  always_comb begin
    f_diff = {sat_err[ERR_W-1], sat_err} - {err_q[ERR_W-1], err_q};
    f_sum  = {err_q[ERR_W-1], err_q} + (f_diff >>> FILT_SHIFT);
  end

  line_err_sat #(
    .IN_W  (ERR_W + 1),
    .OUT_W (ERR_W)
  ) u_filt_sat (
    .din  (f_sum),
    .dout (f_sat)
  );
`endif

  // Next-state and next-value logic for the frame sequencer.
  always_comb begin
    state_nxt   = state;
    k_nxt       = k;
    acc_nxt     = acc;
    sum_nxt     = sum;
    err_nxt     = err_q;
    line_nxt    = line_present;
    err_vld_nxt = 1'b0;
    busy_nxt    = busy;
    ovr_nxt     = IR_vld && (state != IDLE);
    snap_ld     = 1'b0;
`ifdef LINE_ERR_FILT_EN
    primed_nxt  = primed;
`endif
    case (state)
      IDLE: begin
        if (IR_vld && CFG_OK) begin
          snap_ld   = 1'b1;
          acc_nxt   = '0;
          sum_nxt   = '0;
          k_nxt     = '0;
          busy_nxt  = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        acc_nxt = acc + term;
        sum_nxt = sum + {{(SUM_W - ADC_W){1'b0}}, r_k} + {{(SUM_W - ADC_W){1'b0}}, l_k};
        if (k == K_LAST) begin
          k_nxt     = '0;
          state_nxt = FINISH;
        end else begin
          k_nxt = k + K_W'(1);
        end
      end
      FINISH: begin
`ifdef LINE_ERR_FILT_EN
        if (line_now) begin
          err_nxt    = primed ? f_sat : sat_err;
          primed_nxt = 1'b1;
        end
`else
        err_nxt     = sat_err;
`endif
        line_nxt    = line_now;
        err_vld_nxt = 1'b1;
        busy_nxt    = 1'b0;
        state_nxt   = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, accumulators and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      k            <= '0;
      acc          <= '0;
      sum          <= '0;
      err_q        <= '0;
      line_present <= 1'b0;
      err_vld      <= 1'b0;
      busy         <= 1'b0;
      ovr          <= 1'b0;
    end else begin
      state        <= state_nxt;
      k            <= k_nxt;
      acc          <= acc_nxt;
      sum          <= sum_nxt;
      err_q        <= err_nxt;
      line_present <= line_nxt;
      err_vld      <= err_vld_nxt;
      busy         <= busy_nxt;
      ovr          <= ovr_nxt;
    end
  end

`ifdef LINE_ERR_FILT_EN
  // Filter priming flag: first line-present frame after reset loads directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) primed <= 1'b0;
    else     primed <= primed_nxt;
  end
`endif

  // Input snapshot, captured only when a frame is accepted.
  always_ff @(posedge clk) begin
    if (snap_ld) begin
      snap_r <= ir_r;
      snap_l <= ir_l;
    end
  end

endmodule

// File: doc/line_err_engine.md
Name: line_err_engine

Overview:
- Parametrised successor to the fixed 4+4 IR error compute feeding the PID loop.
- Takes N left and N right IR ADC readings.
- Computes a binary-weighted differential steering error, one channel pair per clock, plus a line-present decision.
- Sits between the IR sensor interface and the error mux/PID; a registered, pulse-qualified result replaces combinational error generation.

Parameters:
- NCH_PER_SIDE, 4, sensors per side (1..6); channel 0 is innermost.
- ADC_W, 12, unsigned width of each IR reading.
- ERR_W, 16, signed width of the error output.
- LINE_THRESH, 512, minimum sum of all 2N readings for line_present=1.
- FILT_SHIFT, 2, IIR smoothing shift; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- IR_vld  in  1  one-cycle pulse: new readings are valid.
- ir_r  in  NCH_PER_SIDE*ADC_W  right readings; channel k at [k*ADC_W +: ADC_W].
- ir_l  in  NCH_PER_SIDE*ADC_W  left readings, same packing.
- error  out  ERR_W  signed steering error, held between updates.
- err_vld  out  1  one-cycle pulse when error/line_present update.
- line_present  out  1  line detected in last completed frame.
- busy  out  1  computation in progress.
- ovr  out  1  one-cycle pulse: IR_vld dropped because busy.

Behaviour:
- Reset values, asynchronous on rst: all outputs 0, state IDLE, accumulators 0, channel counter 0.
- FSM states: IDLE, ACCUM, FINISH.
- IDLE:
  - IR_vld=1 latches ir_r/ir_l into an internal snapshot, clears acc and sum, sets k=0, goes to ACCUM, sets busy=1.
  - Inputs are not sampled again until the next accepted frame.
- ACCUM, one edge per channel:
  - acc += sign-extended (R[k] − L[k]) <<< k.
  - sum += R[k] + L[k].
  - k++. At k = NCH_PER_SIDE−1, move to FINISH.
- FINISH:
  - error ← saturate(acc) to ERR_W signed range [−2^(ERR_W−1), 2^(ERR_W−1)−1].
  - line_present ← (sum >= LINE_THRESH).
  - err_vld=1 for one cycle, busy=0, return to IDLE.
- Latency: if IR_vld is sampled at edge E0, outputs and err_vld update at edge E(NCH_PER_SIDE+1); busy is high over E0..E(NCH_PER_SIDE+1).
- Throughput: one frame per NCH_PER_SIDE+2 cycles.
- Widths:
  - acc is signed, ACC_W = ADC_W + NCH_PER_SIDE + 2 bits; it never overflows internally.
  - sum is unsigned, ADC_W + clog2(2*NCH_PER_SIDE) + 1 bits.
- Sign convention: positive error means more right-side reflectance.
- IR_vld while busy (ACCUM or FINISH): frame ignored, ovr pulses at the next edge, the in-flight computation is unaffected.
- IR_vld in the same cycle err_vld is high: state is IDLE, so it is accepted normally.
- Reset mid-frame: computation abandoned, outputs return to reset values, no err_vld.
- line_present=0 does not zero error; selection versus open-loop error stays downstream.

Optional Feature:
- Macro: LINE_ERR_FILT_EN.
- Defined:
  - In FINISH, error ← error + ((sat − error) >>> FILT_SHIFT), computed at ERR_W+1 bits then saturated.
  - The first frame after reset loads sat directly; a "primed" flag is cleared by rst.
  - Only frames with line_present=1 update the filter; otherwise error holds and err_vld still pulses.
- Undefined: error = saturate(acc) each frame, and the FILT_SHIFT parameter is unused.

Decomposition:
- Package line_err_pkg:
  - FSM state enum.
  - Functions acc_width(), sum_width(), sat_signed().
  - Default threshold constants.
- One natural sub-module, line_err_sat: parametrised signed saturator ACC_W→ERR_W, reused by the optional filter path.
- Counter, FSM and snapshot stay in line_err_engine.

Test Plan (defaults: NCH_PER_SIDE=4, ADC_W=12, ERR_W=16, LINE_THRESH=512):
1. All readings 0, IR_vld pulse → err_vld exactly 5 cycles later, error=0, line_present=0, busy high for 5 edges.
2. R3=0xFFF, others 0 → error=+32760, line_present=1; mirror with L3=0xFFF → error=−32760.
3. R3=R2=0xFFF, others 0 → raw 49140, error saturates to +32767; L3=L2=0xFFF → −32768.
4. Second IR_vld 2 cycles after the first → ovr pulses once, single err_vld, result from first frame only; IR_vld coincident with err_vld → accepted, next err_vld 5 cycles later.
5. rst asserted during ACCUM (cycle 3) → outputs 0 immediately, no err_vld; next frame R0=100, L0=0 → error=100, line_present=0 (sum 100 < 512).
6. With LINE_ERR_FILT_EN and FILT_SHIFT=2: frame R1=1000 (raw 2000) then R1=0,L1=0,R0=600 (raw 600, sum 600) → error 2000, then 1650.
